// File: rtl/if_id_fetch_buffer.sv
// IF/ID decoupling FIFO: buffers {instr, pc, pc+4} from fetch, presents the head entry to decode.
// Optional FETCH_BUF_PERF_EN adds saturating stall_cycles / flush_count counters.
module if_id_fetch_buffer #(
   parameter int               WIDTH = 32,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] NOP   = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_f,
   input  logic [WIDTH-1:0] instr_f,
   input  logic [WIDTH-1:0] pc_f,
   input  logic [WIDTH-1:0] pc_plus4_f,
   output logic             ready_f,
   input  logic             flush,
   input  logic             stall_d,
   output logic             valid_d,
   output logic [WIDTH-1:0] instr_d,
   output logic [WIDTH-1:0] pc_d,
   output logic [WIDTH-1:0] pc_plus4_d
`ifdef FETCH_BUF_PERF_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] instr_mem_r [DEPTH];
   logic [WIDTH-1:0] pc_mem_r    [DEPTH];
   logic [WIDTH-1:0] pc4_mem_r   [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             ready_s;
   logic             valid_s;
   logic             push_s;
   logic             pop_s;

   // Handshake decode and head-entry output mux; empty buffer shows NOP/0 so storage is never read unwritten.
   always_comb begin
      ready_s    = (count_r != FULL_CNT);
      valid_s    = (count_r != {CNT_W{1'b0}});
      push_s     = valid_f & ready_s & ~flush;
      pop_s      = valid_s & ~stall_d & ~flush;
      instr_d    = NOP;
      pc_d       = {WIDTH{1'b0}};
      pc_plus4_d = {WIDTH{1'b0}};
      if (valid_s) begin
         instr_d    = instr_mem_r[rd_ptr_r];
         pc_d       = pc_mem_r[rd_ptr_r];
         pc_plus4_d = pc4_mem_r[rd_ptr_r];
      end else begin
         instr_d    = NOP;
         pc_d       = {WIDTH{1'b0}};
         pc_plus4_d = {WIDTH{1'b0}};
      end
   end

   assign ready_f = ready_s;
   assign valid_d = valid_s;

   // Entry storage; contents are don't-care once popped or flushed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         instr_mem_r[wr_ptr_r] <= instr_f;
         pc_mem_r[wr_ptr_r]    <= pc_f;
         pc4_mem_r[wr_ptr_r]   <= pc_plus4_f;
      end
   end

   // Pointer and occupancy update; reset dominates flush, flush dominates push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef FETCH_BUF_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'h0000_0000;
         flush_count  <= 32'h0000_0000;
      end else begin
         if (valid_f && !ready_s && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'h0000_0001;
         end else begin
            stall_cycles <= stall_cycles;
         end
         if (flush && (flush_count != 32'hFFFF_FFFF)) begin
            flush_count <= flush_count + 32'h0000_0001;
         end else begin
            flush_count <= flush_count;
         end
      end
   end
`endif

endmodule
